// File: rtl/gray_counter.sv
// Up/down binary counter with registered Gray output and terminal-count flag,
// plus an independent Gray-to-binary decoder with a sticky multi-bit-step checker.
module gray_counter #(
    parameter int WIDTH = 4,
    parameter int WRAP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             tc,
    input  logic             dec_valid_in,
    input  logic [WIDTH-1:0] dec_gray_in,
    output logic             dec_valid_out,
    output logic [WIDTH-1:0] dec_bin_out,
    output logic             gray_err,
    input  logic             err_clr
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] MAX  = '1;

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             tc_q, tc_d;

    logic [WIDTH-1:0] dec_bin_q, dec_bin_d;
    logic             dec_valid_q, dec_valid_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic             ref_valid_q, ref_valid_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] dec_calc;
    logic [WIDTH-1:0] diff;
    logic             new_err;

    always_comb begin
        bin_d = bin_q;
        tc_d  = 1'b0;
        if (load) begin
            bin_d = load_val;
        end else if (en) begin
            if (up) begin
                if (bin_q == MAX) begin
                    tc_d  = 1'b1;
                    bin_d = (WRAP != 0) ? ZERO : bin_q;
                end else begin
                    bin_d = bin_q + ONE;
                end
            end else begin
                if (bin_q == ZERO) begin
                    tc_d  = 1'b1;
                    bin_d = (WRAP != 0) ? MAX : bin_q;
                end else begin
                    bin_d = bin_q - ONE;
                end
            end
        end
        // Gray is derived from the next binary value so both flops agree every cycle
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_comb begin
        dec_calc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dec_calc[i] = ^(dec_gray_in >> i);
        end
        diff        = dec_gray_in ^ ref_q;
        // clearing the lowest set bit leaves something only if two or more bits differ
        new_err     = dec_valid_in & ref_valid_q & (|(diff & (diff - ONE)));
        dec_valid_d = dec_valid_in;
        dec_bin_d   = dec_bin_q;
        ref_d       = ref_q;
        ref_valid_d = ref_valid_q;
        err_d       = err_q;
        if (dec_valid_in) begin
            dec_bin_d   = dec_calc;
            ref_d       = dec_gray_in;
            ref_valid_d = 1'b1;
        end
        if (new_err) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q       <= '0;
            gray_q      <= '0;
            tc_q        <= 1'b0;
            dec_bin_q   <= '0;
            dec_valid_q <= 1'b0;
            ref_q       <= '0;
            ref_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            bin_q       <= bin_d;
            gray_q      <= gray_d;
            tc_q        <= tc_d;
            dec_bin_q   <= dec_bin_d;
            dec_valid_q <= dec_valid_d;
            ref_q       <= ref_d;
            ref_valid_q <= ref_valid_d;
            err_q       <= err_d;
        end
    end

    assign bin_out       = bin_q;
    assign gray_out      = gray_q;
    assign tc            = tc_q;
    assign dec_bin_out   = dec_bin_q;
    assign dec_valid_out = dec_valid_q;
    assign gray_err      = err_q;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench: a wrapping and a saturating instance; stimulus queues the
// hand-computed post-edge state, a monitor pops and compares after each edge.
module tb_gray_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       en1 = 0, up1 = 0, load1 = 0;
    logic [3:0] lv1 = 0;
    logic [3:0] bin1, gray1;
    logic       tc1;
    logic       dvi = 0, eclr = 0;
    logic [3:0] dgi = 0;
    logic       dvo;
    logic [3:0] dbo;
    logic       gerr;

    logic       en0 = 0, up0 = 0, load0 = 0;
    logic [3:0] lv0 = 0;
    logic [3:0] bin0, gray0;
    logic       tc0;
    logic       dvo0;
    logic [3:0] dbo0;
    logic       gerr0;

    gray_counter #(.WIDTH(4), .WRAP(1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(en1), .up(up1), .load(load1), .load_val(lv1),
        .bin_out(bin1), .gray_out(gray1), .tc(tc1),
        .dec_valid_in(dvi), .dec_gray_in(dgi), .dec_valid_out(dvo),
        .dec_bin_out(dbo), .gray_err(gerr), .err_clr(eclr)
    );

    gray_counter #(.WIDTH(4), .WRAP(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en0), .up(up0), .load(load0), .load_val(lv0),
        .bin_out(bin0), .gray_out(gray0), .tc(tc0),
        .dec_valid_in(1'b0), .dec_gray_in(4'b0000), .dec_valid_out(dvo0),
        .dec_bin_out(dbo0), .gray_err(gerr0), .err_clr(1'b0)
    );

    typedef struct {
        logic [3:0] b1; logic t1;
        logic [3:0] b0; logic t0;
        logic dv; logic [3:0] db; logic er;
    } exp_t;

    exp_t sb[$];
    logic [3:0] x_b1 = 0, x_b0 = 0, x_db = 0;
    logic       x_t1 = 0, x_t0 = 0, x_dv = 0, x_er = 0;

    logic [3:0] gray_tbl [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                  4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                  4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                  4'b1010, 4'b1011, 4'b1001, 4'b1000};

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("wrap_bin",  32'(bin1),  32'(e.b1));
            chk("wrap_gray", 32'(gray1), 32'(gray_tbl[e.b1]));
            chk("wrap_tc",   32'(tc1),   32'(e.t1));
            chk("sat_bin",   32'(bin0),  32'(e.b0));
            chk("sat_gray",  32'(gray0), 32'(gray_tbl[e.b0]));
            chk("sat_tc",    32'(tc0),   32'(e.t0));
            chk("dec_valid", 32'(dvo),   32'(e.dv));
            chk("dec_bin",   32'(dbo),   32'(e.db));
            chk("gray_err",  32'(gerr),  32'(e.er));
        end
    end

    // queue the expected state after the coming edge, then wait for the next negedge
    task automatic cyc();
        exp_t e;
        e = '{b1: x_b1, t1: x_t1, b0: x_b0, t0: x_t0, dv: x_dv, db: x_db, er: x_er};
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic dec(input logic v, input logic [3:0] g, input logic clr,
                       input logic [3:0] eb, input logic ee);
        dvi = v; dgi = g; eclr = clr;
        x_dv = v;
        if (v) x_db = eb;
        x_er = ee;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bin1"}, 32'(bin1), 0);
        chk({tag, "_gray1"}, 32'(gray1), 0);
        chk({tag, "_tc1"}, 32'(tc1), 0);
        chk({tag, "_bin0"}, 32'(bin0), 0);
        chk({tag, "_tc0"}, 32'(tc0), 0);
        chk({tag, "_dvo"}, 32'(dvo), 0);
        chk({tag, "_dbo"}, 32'(dbo), 0);
        chk({tag, "_err"}, 32'(gerr), 0);
    endtask

    initial begin
        #3;
        chk_all_zero("reset");
        #4 rst_n = 1'b1;
        @(negedge clk);

        // wrapping up-count through a full cycle plus one
        en1 = 1; up1 = 1;
        for (int k = 1; k <= 17; k++) begin
            x_b1 = 4'(k % 16);
            x_t1 = (k == 16);
            cyc();
        end

        // load beats enable, then count down, then wrap downward
        load1 = 1; lv1 = 4'b0101; x_b1 = 4'd5; x_t1 = 0; cyc();
        load1 = 0; up1 = 0; x_b1 = 4'd4; cyc();
        x_b1 = 4'd3; cyc();
        load1 = 1; lv1 = 4'd1; x_b1 = 4'd1; cyc();
        load1 = 0; x_b1 = 4'd0; cyc();
        x_b1 = 4'd15; x_t1 = 1; cyc();
        en1 = 0; x_t1 = 0; cyc();

        // saturating instance runs alongside the decoder scenario
        load0 = 1; lv0 = 4'd14; en0 = 1; up0 = 1; x_b0 = 4'd14;
        dec(1, 4'b0000, 0, 4'd0, 0); cyc();
        load0 = 0; x_b0 = 4'd15;
        dec(1, 4'b0001, 0, 4'd1, 0); cyc();
        x_t0 = 1;
        dec(1, 4'b0011, 0, 4'd2, 0); cyc();
        dec(1, 4'b0110, 0, 4'd4, 1); cyc();
        dec(0, 4'b1111, 0, 4'd4, 1); cyc();
        up0 = 0; x_b0 = 4'd14; x_t0 = 0;
        dec(1, 4'b0111, 1, 4'd5, 0); cyc();
        load0 = 1; lv0 = 4'd0; x_b0 = 4'd0;
        dec(1, 4'b0000, 1, 4'd0, 1); cyc();
        load0 = 0; x_t0 = 1;
        dec(0, 4'b0000, 1, 4'd0, 0); cyc();
        en0 = 0; x_t0 = 0;
        dec(1, 4'b1100, 0, 4'd8, 1); cyc();

        // bring the wrap counter to 1001 with a live decoder output, then reset mid-cycle
        load1 = 1; lv1 = 4'b1001; x_b1 = 4'd9;
        dec(1, 4'b1101, 1, 4'd9, 0); cyc();
        load1 = 0; dvi = 0; eclr = 0;
        chk("pre_rst_bin1", 32'(bin1), 9);
        chk("pre_rst_dvo", 32'(dvo), 1);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        #1 rst_n = 1'b1;
        x_b1 = 0; x_t1 = 0; x_b0 = 0; x_t0 = 0; x_dv = 0; x_db = 0; x_er = 0;

        // empty reference: far sample must not flag, the following one must
        dec(1, 4'b1111, 0, 4'd10, 0); cyc();
        dec(1, 4'b0000, 0, 4'd0, 1); cyc();
        dec(0, 4'b0000, 0, 4'd0, 1); cyc();

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 0);
        chk("sat_dec_idle", 32'({dvo0, gerr0, dbo0}), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        fails++;
        $display("FAIL watchdog: timeout reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning counter and decoder bit width (legal range 2..32).
REQ-002 SHALL have parameter WRAP, default 1, meaning 1 = modulo wrap at the end of the range, 0 = saturate at the end of the range.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-005 SHALL have port en, input, 1 bit, count step enable.
REQ-006 SHALL have port up, input, 1 bit, direction select: 1 = increment, 0 = decrement.
REQ-007 SHALL have port load, input, 1 bit, synchronous load strobe.
REQ-008 SHALL have port load_val, input, WIDTH bits, binary value to load.
REQ-009 SHALL have port bin_out, output, WIDTH bits, registered binary count.
REQ-010 SHALL have port gray_out, output, WIDTH bits, registered Gray code of bin_out.
REQ-011 SHALL have port tc, output, 1 bit, registered terminal-count flag.
REQ-012 SHALL have port dec_valid_in, input, 1 bit, decoder sample valid.
REQ-013 SHALL have port dec_gray_in, input, WIDTH bits, Gray sample to decode.
REQ-014 SHALL have port dec_valid_out, output, 1 bit, decoded sample valid.
REQ-015 SHALL have port dec_bin_out, output, WIDTH bits, decoded binary sample.
REQ-016 SHALL have port gray_err, output, 1 bit, sticky multi-bit-step error flag.
REQ-017 SHALL have port err_clr, input, 1 bit, synchronous clear for gray_err.

Function
REQ-018 SHALL keep gray_out equal to bin_out ^ (bin_out >> 1) in every cycle; both SHALL be registered on the same edge, with no combinational path from inputs to outputs.
REQ-019 SHALL give load priority over en: when load=1, bin_out <= load_val, gray_out <= Gray(load_val), and tc <= 0, regardless of en and up.
REQ-020 SHALL hold bin_out, gray_out and tc constant when load=0 and en=0; tc from a previous step SHALL drop to 0.
REQ-021 SHALL step bin_out by +1 (up=1) or -1 (up=0) modulo 2^WIDTH when load=0, en=1 and the step does not cross a range end.
REQ-022 Range crossing, WRAP=1: when up=1 with bin_out=2^WIDTH-1, SHALL go to 0; when up=0 with bin_out=0, SHALL go to 2^WIDTH-1; tc SHALL be 1 in the following cycle.
REQ-023 Range crossing, WRAP=0: in the same two cases, bin_out SHALL hold; tc SHALL be 1 in the following cycle and SHALL stay 1 while en=1 and the saturated direction is held.
REQ-024 SHALL set tc to 0 after any non-crossing step; tc is a one-cycle pulse per wrap in WRAP=1 mode.
REQ-025 SHALL make a direction change take effect on the same edge with no dead cycle; each single step changes exactly one bit of gray_out.
REQ-026 Decoder: on a clock edge with dec_valid_in=1, SHALL register dec_bin_out[i] = XOR of dec_gray_in[WIDTH-1:i] and set dec_valid_out=1, giving a latency of exactly 1 cycle.
REQ-027 Decoder: on a clock edge with dec_valid_in=0, SHALL set dec_valid_out=0 and hold dec_bin_out.
REQ-028 Error check: SHALL store the last valid dec_gray_in. On each later valid sample whose Hamming distance from the stored one is greater than 1, SHALL set gray_err=1 on that edge. The first valid sample after reset SHALL never flag.
REQ-029 SHALL clear gray_err when err_clr=1. If a new error is detected in the same cycle as err_clr=1, the error SHALL win and gray_err stays 1.
REQ-030 SHALL operate the decoder and error checker independently of the counter; simultaneous activity on both paths SHALL not interact.

Reset
REQ-031 SHALL, while rst_n=0 and independent of clk, force: bin_out=0, gray_out=0, tc=0, dec_bin_out=0, dec_valid_out=0, gray_err=0; the stored reference sample SHALL be marked empty.
REQ-032 SHALL take an assertion of rst_n in the middle of a count, load or decode immediately, with no completion of the pending update.
REQ-033 SHALL treat the first rising clk after rst_n deasserts as a normal functional edge.

Verification (WIDTH=4)
REQ-034 Up-count with en=1, up=1, WRAP=1 for 17 cycles from reset: gray_out follows 0000,0001,0011,0010,...,1000,0000; tc=1 for exactly the one cycle after 15->0.
REQ-035 load=1, load_val=0101, en=1 on the same edge: bin_out=0101, gray_out=0111, tc=0; then up=0 for two steps gives bin_out 0100, then 0011.
REQ-036 WRAP=0, at bin_out=1111, up=1, en=1 for 3 cycles: bin_out stays 1111 and tc stays 1; switching to up=0 gives 1110 and tc=0.
REQ-037 Decoder fed 0000,0001,0011,0110 with valid: dec_bin_out 0,1,2,4 one cycle later each; gray_err rises on the 0110 edge; err_clr=1 then returns it to 0.
REQ-038 Pulse rst_n low asynchronously between edges at bin_out=1001 with dec_valid_out=1: all outputs are 0 immediately; the next valid decoder sample does not flag gray_err.
